// File: rtl/gs_mixer.sv
// N-channel volume/route mixer into left/right sums; saturating output when GS_MIXER_SATURATE_EN is defined, wrapping otherwise.
// Latency: ce to out_valid is CHANNELS+1 clocks; one channel is accumulated per clock.
// Backpressure: none; a ce arriving while busy is dropped and flagged on overrun one clock later.
module gs_mixer #(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 6,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0
) (
  input  logic                         clk_sys,
  input  logic                         areset,
  input  logic                         ce,
  input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
  input  logic [CHANNELS*VOL_W-1:0]    ch_vol,
  input  logic [CHANNELS*2-1:0]        ch_route,
  output logic [OUT_W-1:0]             out_l,
  output logic [OUT_W-1:0]             out_r,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int PROD_W = SAMPLE_W + VOL_W;
  // Sized so that CHANNELS full-scale products can never wrap.
  localparam int ACC_W  = PROD_W + $clog2(CHANNELS);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [ACC_W-1:0]             acc_l;
  logic [ACC_W-1:0]             acc_r;
  logic [CHANNELS*SAMPLE_W-1:0] data_q;
  logic [CHANNELS*VOL_W-1:0]    vol_q;
  logic [CHANNELS*2-1:0]        route_q;

  logic [SAMPLE_W-1:0] cur_data;
  logic [VOL_W-1:0]    cur_vol;
  logic [1:0]          cur_route;
  logic [PROD_W-1:0]   prod;
  logic [OUT_W-1:0]    mix_l;
  logic [OUT_W-1:0]    mix_r;

  assign cur_data  = data_q[int'(idx)*SAMPLE_W +: SAMPLE_W];
  assign cur_vol   = vol_q[int'(idx)*VOL_W +: VOL_W];
  assign cur_route = route_q[int'(idx)*2 +: 2];
  assign prod      = PROD_W'(cur_data) * PROD_W'(cur_vol);

`ifdef GS_MIXER_SATURATE_EN
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  logic [EXT_W-1:0] sh_l;
  logic [EXT_W-1:0] sh_r;

  assign sh_l  = EXT_W'(acc_l >> SHIFT);
  assign sh_r  = EXT_W'(acc_r >> SHIFT);
  // Any bit above OUT_W means the value does not fit: clamp to full scale.
  assign mix_l = (|(sh_l >> OUT_W)) ? {OUT_W{1'b1}} : sh_l[OUT_W-1:0];
  assign mix_r = (|(sh_r >> OUT_W)) ? {OUT_W{1'b1}} : sh_r[OUT_W-1:0];
`else
  assign mix_l = OUT_W'(acc_l >> SHIFT);
  assign mix_r = OUT_W'(acc_r >> SHIFT);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk_sys or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      data_q    <= '0;
      vol_q     <= '0;
      route_q   <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= ce && (state != IDLE);
      case (state)
        IDLE: begin
          if (ce) begin
            // Snapshot so late input changes cannot leak into this mix.
            data_q  <= ch_data;
            vol_q   <= ch_vol;
            route_q <= ch_route;
            acc_l   <= '0;
            acc_r   <= '0;
            idx     <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          if (cur_route[0]) acc_l <= acc_l + ACC_W'(prod);
          if (cur_route[1]) acc_r <= acc_r + ACC_W'(prod);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          out_l     <= mix_l;
          out_r     <= mix_r;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
